io_port_fifo_endpoint: RTL
==========================

// Module: io_port_fifo_endpoint
// PURPOSE
//  Peripheral-side responder for the Datapath I/O port handshake.
//  Per port: an inbound FIFO (external producer -> Datapath read side) and an outbound FIFO (Datapath write side -> external consumer).
//  Drives io_read_EF/io_read_data and io_write_EF; consumes io_rden/io_wren/io_write_data.
//  Sits between the Datapath port buses and valid/ready peripheral logic.
// PARAMETERS
//  WORD_WIDTH       36  data word width
//  IO_PORT_COUNT    3   number of ports (A or B side; instantiate once per side)
//  FIFO_DEPTH       4   entries per FIFO, power of 2, >=2
//  FIFO_ADDR_WIDTH  2   log2(FIFO_DEPTH)
// PORTS
//  clock          in   1                    system clock
//  reset          in   1                    async, active-high
//  io_rden        in   IO_PORT_COUNT        Datapath pops inbound head of port i
//  io_read_EF     out  IO_PORT_COUNT        1 = inbound FIFO i non-empty (read ready)
//  io_read_data   out  IO_PORT_COUNT*WW     inbound head words, port i at [i*WW +: WW]
//  io_wren        in   IO_PORT_COUNT        Datapath pushes io_write_data slice i
//  io_write_data  in   IO_PORT_COUNT*WW     outbound words from Datapath
//  io_write_EF    out  IO_PORT_COUNT        1 = outbound FIFO i full (write not ready)
//  ext_in_valid   in   IO_PORT_COUNT        producer word valid
//  ext_in_ready   out  IO_PORT_COUNT        inbound FIFO i can accept
//  ext_in_data    in   IO_PORT_COUNT*WW     producer words
//  ext_out_valid  out  IO_PORT_COUNT        outbound FIFO i non-empty
//  ext_out_ready  in   IO_PORT_COUNT        consumer accepts
//  ext_out_data   out  IO_PORT_COUNT*WW     outbound head words
//  err_underflow  out  IO_PORT_COUNT        sticky (optional feature only)
//  err_overflow   out  IO_PORT_COUNT        sticky (optional feature only)
// BEHAVIOUR
//  - Per FIFO: wr_ptr, rd_ptr (FIFO_ADDR_WIDTH, wrap modulo depth), count (FIFO_ADDR_WIDTH+1 bits, 0..FIFO_DEPTH).
//  - All flags are decoded from registered count only: full = (count==FIFO_DEPTH), empty = (count==0).
//  - Inbound push on ext_in_valid & ext_in_ready. Inbound pop on io_rden & !empty.
//  - Outbound push on io_wren & !full. Outbound pop on ext_out_valid & ext_out_ready.
//  - Heads are first-word-fall-through: io_read_data/ext_out_data = mem[rd_ptr], combinational from storage. Value is undefined when empty.
//  - Latency: a word pushed at edge N is visible with EF/valid high after edge N (1 cycle).
//    Freed space is visible (ready high / write_EF low) after the pop edge.
//  - Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
//  - Push when full:
//    - Inbound: impossible, because ready is low.
//    - Outbound io_wren while full: word dropped, count and pointers unchanged.
//  - Pop when empty (io_rden while !io_read_EF): ignored, state unchanged.
//  - Empty FIFO with push and io_rden in the same cycle: the push is accepted and the rden is ignored (it counts as underflow).
//  - Reset (any time, including mid-transfer): pointers and counts cleared; storage contents are not cleared.
//    While reset is high:
//      io_read_EF = 0, ext_out_valid = 0
//      ext_in_ready = 0, io_write_EF = all 1s (not ready)
//    After reset deasserts:
//      ext_in_ready = 1, io_write_EF = 0
//  - Ports are fully independent; no cross-port arbitration.
// CONFIGURATION
//  IO_PORT_FIFO_ENDPOINT_ERR_EN defined:
//   - err_underflow[i] set on io_rden[i] while inbound i empty.
//   - err_overflow[i] set on io_wren[i] while outbound i full.
//   - Both bits are sticky until reset; reset value 0.
//  Not defined: err_underflow and err_overflow are tied to 0 and no error registers exist.
// TESTING (WORD_WIDTH=36, IO_PORT_COUNT=3, FIFO_DEPTH=4)
//  1. Reset released, no traffic -> io_read_EF=3'b000, io_write_EF=3'b000, ext_in_ready=3'b111, ext_out_valid=3'b000.
//  2. Push 1,2,3,4 into inbound port 0 -> ext_in_ready[0]=0 after the 4th push.
//     Then io_rden[0] for 4 cycles -> data 1,2,3,4 in order, io_read_EF[0]=0 after the last pop.
//  3. io_wren[2] with 36'd6 x4 while ext_out_ready[2]=0 -> io_write_EF[2]=1.
//     A 5th wren (36'd7) is dropped. With ERR_EN, err_overflow[2]=1.
//     Drain -> four 6s, no 7.
//  4. Outbound port 1 holds 2 words; io_wren[1] and ext_out_ready[1] asserted together for 10 cycles
//     -> count stays 2, order preserved, pointers wrap cleanly.
//  5. io_rden[1] on empty inbound port 1 in the same cycle as ext_in push of 36'd5
//     -> 36'd5 retained, io_read_EF[1]=1 next cycle. With ERR_EN, err_underflow[1]=1.
//  6. Assert reset with all FIFOs partly full -> EF/valid low and io_write_EF=3'b111 immediately (async).
//     After release, FIFOs empty and ext_in_ready=3'b111.

Source files
------------

// File: rtl/io_port_fifo_endpoint.sv
// Responder side of the Datapath I/O port handshake: each port has an inbound and an outbound FWFT FIFO.
// Optional sticky underflow/overflow flags are enabled by defining IO_PORT_FIFO_ENDPOINT_ERR_EN.

module io_port_fifo_endpoint_fifo #(
  parameter int WORD_WIDTH      = 36,
  parameter int FIFO_DEPTH      = 4,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_COUNT = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);

  logic [WORD_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [FIFO_ADDR_WIDTH:0]   count_reg;
  logic                       push_fire;
  logic                       pop_fire;

  // Flags come from the registered count only, never from this cycle's requests.
  assign full      = (count_reg == DEPTH_COUNT);
  assign empty     = (count_reg == '0);
  assign push_fire = push & ~full;
  assign pop_fire  = pop & ~empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr_reg <= wr_ptr_reg + (FIFO_ADDR_WIDTH)'(1);
      end
      if (pop_fire) begin
        rd_ptr_reg <= rd_ptr_reg + (FIFO_ADDR_WIDTH)'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   count_reg <= count_reg + (FIFO_ADDR_WIDTH+1)'(1);
        2'b01:   count_reg <= count_reg - (FIFO_ADDR_WIDTH+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is deliberately left out of reset so it can map onto plain RAM.
  always_ff @(posedge clock) begin
    if (push_fire) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_reg];

endmodule

module io_port_fifo_endpoint #(
  parameter int WORD_WIDTH      = 36,
  parameter int IO_PORT_COUNT   = 3,
  parameter int FIFO_DEPTH      = 4,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [IO_PORT_COUNT-1:0]            io_rden,
  output logic [IO_PORT_COUNT-1:0]            io_read_EF,
  output logic [IO_PORT_COUNT*WORD_WIDTH-1:0] io_read_data,
  input  logic [IO_PORT_COUNT-1:0]            io_wren,
  input  logic [IO_PORT_COUNT*WORD_WIDTH-1:0] io_write_data,
  output logic [IO_PORT_COUNT-1:0]            io_write_EF,
  input  logic [IO_PORT_COUNT-1:0]            ext_in_valid,
  output logic [IO_PORT_COUNT-1:0]            ext_in_ready,
  input  logic [IO_PORT_COUNT*WORD_WIDTH-1:0] ext_in_data,
  output logic [IO_PORT_COUNT-1:0]            ext_out_valid,
  input  logic [IO_PORT_COUNT-1:0]            ext_out_ready,
  output logic [IO_PORT_COUNT*WORD_WIDTH-1:0] ext_out_data,
  output logic [IO_PORT_COUNT-1:0]            err_underflow,
  output logic [IO_PORT_COUNT-1:0]            err_overflow
);

  logic [IO_PORT_COUNT-1:0] in_full;
  logic [IO_PORT_COUNT-1:0] in_empty;
  logic [IO_PORT_COUNT-1:0] out_full;
  logic [IO_PORT_COUNT-1:0] out_empty;

  generate
    for (genvar gi = 0; gi < IO_PORT_COUNT; gi++) begin : g_port
      io_port_fifo_endpoint_fifo #(
        .WORD_WIDTH     (WORD_WIDTH),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .FIFO_ADDR_WIDTH(FIFO_ADDR_WIDTH)
      ) u_inbound (
        .clock  (clock),
        .reset  (reset),
        .push   (ext_in_valid[gi] & ext_in_ready[gi]),
        .pop    (io_rden[gi]),
        .wr_data(ext_in_data[gi*WORD_WIDTH +: WORD_WIDTH]),
        .rd_data(io_read_data[gi*WORD_WIDTH +: WORD_WIDTH]),
        .full   (in_full[gi]),
        .empty  (in_empty[gi])
      );

      io_port_fifo_endpoint_fifo #(
        .WORD_WIDTH     (WORD_WIDTH),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .FIFO_ADDR_WIDTH(FIFO_ADDR_WIDTH)
      ) u_outbound (
        .clock  (clock),
        .reset  (reset),
        .push   (io_wren[gi]),
        .pop    (ext_out_ready[gi]),
        .wr_data(io_write_data[gi*WORD_WIDTH +: WORD_WIDTH]),
        .rd_data(ext_out_data[gi*WORD_WIDTH +: WORD_WIDTH]),
        .full   (out_full[gi]),
        .empty  (out_empty[gi])
      );
    end
  endgenerate

  // Reset forces both write-side handshakes to "not ready" immediately, independent of the clock.
  assign io_read_EF    = ~in_empty;
  assign ext_out_valid = ~out_empty;
  assign ext_in_ready  = reset ? '0 : ~in_full;
  assign io_write_EF   = reset ? '1 : out_full;

`ifdef IO_PORT_FIFO_ENDPOINT_ERR_EN
  logic [IO_PORT_COUNT-1:0] err_underflow_reg;
  logic [IO_PORT_COUNT-1:0] err_overflow_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_underflow_reg <= '0;
      err_overflow_reg  <= '0;
    end else begin
      err_underflow_reg <= err_underflow_reg | (io_rden & in_empty);
      err_overflow_reg  <= err_overflow_reg | (io_wren & out_full);
    end
  end

  assign err_underflow = err_underflow_reg;
  assign err_overflow  = err_overflow_reg;
`else
  assign err_underflow = '0;
  assign err_overflow  = '0;
`endif

endmodule
